// File: rtl/max7219_pkg.sv
// Shared register addresses, glyph codes and state encodings for the MAX7219 glyph driver.
package max7219_pkg;

    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCAN_LIM  = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    localparam logic [3:0] GLYPH_HAPPY   = 4'd10;
    localparam logic [3:0] GLYPH_NEUTRAL = 4'd11;
    localparam logic [3:0] GLYPH_SAD     = 4'd12;

    localparam logic [3:0] INIT_FRAMES  = 4'd5;
    localparam logic [3:0] BURST_FRAMES = 4'd8;

    typedef enum logic [1:0] {T_INIT, T_IDLE, T_BURST} top_state_t;
    typedef enum logic [1:0] {E_READY, E_LOAD, E_SHIFT, E_GAP} eng_state_t;

    function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
        case (idx)
            3'd0:    init_word = {REG_SHUTDOWN, 8'h01};
            3'd1:    init_word = {REG_DECODE, 8'h00};
            3'd2:    init_word = {REG_SCAN_LIM, 8'h07};
            3'd3:    init_word = {REG_INTENSITY, 4'h0, intensity};
            default: init_word = {REG_TEST, 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/max7219_font.sv
// Combinational 8x8 glyph ROM: digits 0-9, three smileys, blank for codes 13-15.
// Row 0 is the top row; bit 7 is the leftmost column.
module max7219_font
    import max7219_pkg::*;
(
    input  logic [3:0] code,
    input  logic [2:0] row,
    output logic [7:0] data
);

    logic [63:0] bits;

    always_comb begin
        case (code)
            4'd0:          bits = 64'h3C66_6E76_6666_3C00;
            4'd1:          bits = 64'h1838_1818_1818_7E00;
            4'd2:          bits = 64'h3C66_060C_3060_7E00;
            4'd3:          bits = 64'h3C66_061C_0666_3C00;
            4'd4:          bits = 64'h0C1C_3C6C_7E0C_0C00;
            4'd5:          bits = 64'h7E60_7C06_0666_3C00;
            4'd6:          bits = 64'h3C60_7C66_6666_3C00;
            4'd7:          bits = 64'h7E06_0C18_3030_3000;
            4'd8:          bits = 64'h3C66_663C_6666_3C00;
            4'd9:          bits = 64'h3C66_663E_060C_3800;
            GLYPH_HAPPY:   bits = 64'h3C42_A581_A599_423C;
            GLYPH_NEUTRAL: bits = 64'h3C42_A581_BD81_423C;
            GLYPH_SAD:     bits = 64'h3C42_A581_99A5_423C;
            default:       bits = 64'h0;
        endcase
    end

    // {~row, 3'b000} == 8*(7-row): row 0 is the most significant byte
    assign data = bits[{~row, 3'b000} +: 8];

endmodule

// File: rtl/max7219_glyph_driver.sv
// Drives one MAX7219 8x8 matrix: init sequence after reset, then an 8-row refresh on glyph/enable change.
// Latency: CS falls 2 clk after the first IDLE cycle with a changed input; frame period 32*CLK_DIV+CS_GAP+1.
// No backpressure: inputs are sampled only in IDLE; MAX7219_REINIT_EN adds a periodic forced re-init.
module max7219_glyph_driver
    import max7219_pkg::*;
#(
    parameter int          CLK_DIV      = 4,
    parameter int          CS_GAP       = 4,
    parameter logic [3:0]  INTENSITY    = 4'h8,
    parameter logic [23:0] REINIT_TICKS = 24'd1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       enable_display,
    output logic       DIN,
    output logic       CS,
    output logic       SCLK,
    output logic       busy
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam logic [DIV_W-1:0] DIV_MID = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_END = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(CS_GAP - 1);

    top_state_t       top_state;
    eng_state_t       eng_state;
    logic [3:0]       idx;
    logic [4:0]       snap;
    logic             force_refresh;
    logic [15:0]      shreg;
    logic [3:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       font_row;
    logic [15:0]      word;
    logic             gap_last;
    logic             eng_rdy;
    logic             need_burst;
    logic             start;
    logic             reinit_pend;

    max7219_font u_font (
        .code (snap[3:0]),
        .row  (idx[2:0]),
        .data (font_row)
    );

    assign gap_last   = (eng_state == E_GAP) && (gap_cnt == GAP_END);
    // GAP's last cycle counts as ready so back-to-back frames skip an idle cycle
    assign eng_rdy    = (eng_state == E_READY) || gap_last;
    assign need_burst = force_refresh || ({enable_display, digit} != snap);

    always_comb begin
        word = 16'h0;
        if (top_state == T_INIT)
            word = init_word(idx[2:0], INTENSITY);
        else
            word = {4'h0, idx + 4'd1, snap[4] ? font_row : 8'h00};
    end

    always_comb begin
        start = 1'b0;
        case (top_state)
            T_INIT:  start = eng_rdy && (idx != INIT_FRAMES);
            T_IDLE:  start = eng_rdy && !reinit_pend && need_burst;
            T_BURST: start = eng_rdy && (idx != BURST_FRAMES);
            default: start = 1'b0;
        endcase
    end

    // Top sequencer: idx advances as each frame is latched in LOAD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_state     <= T_INIT;
            idx           <= 4'd0;
            snap          <= 5'd0;
            force_refresh <= 1'b1;
        end else begin
            if (eng_state == E_LOAD)
                idx <= idx + 4'd1;
            case (top_state)
                T_INIT: begin
                    if (eng_rdy && idx == INIT_FRAMES) begin
                        top_state <= T_IDLE;
                        idx       <= 4'd0;
                    end
                end
                T_IDLE: begin
                    if (reinit_pend) begin
                        top_state     <= T_INIT;
                        force_refresh <= 1'b1;
                        idx           <= 4'd0;
                    end else if (need_burst) begin
                        top_state     <= T_BURST;
                        snap          <= {enable_display, digit};
                        force_refresh <= 1'b0;
                        idx           <= 4'd0;
                    end
                end
                T_BURST: begin
                    if (eng_rdy && idx == BURST_FRAMES) begin
                        top_state <= T_IDLE;
                        idx       <= 4'd0;
                    end
                end
                default: top_state <= T_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_state <= E_READY;
            CS        <= 1'b1;
            SCLK      <= 1'b0;
            DIN       <= 1'b0;
            busy      <= 1'b0;
            shreg     <= 16'h0;
            bit_cnt   <= 4'd0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            case (eng_state)
                E_READY: begin
                    if (start) begin
                        eng_state <= E_LOAD;
                        busy      <= 1'b1;
                    end
                end
                E_LOAD: begin
                    shreg     <= word;
                    bit_cnt   <= 4'd15;
                    div_cnt   <= '0;
                    CS        <= 1'b0;
                    DIN       <= word[15];
                    eng_state <= E_SHIFT;
                end
                E_SHIFT: begin
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == DIV_MID)
                        SCLK <= 1'b1;
                    if (div_cnt == DIV_END) begin
                        SCLK    <= 1'b0;
                        div_cnt <= '0;
                        if (bit_cnt == 4'd0) begin
                            CS        <= 1'b1;
                            DIN       <= 1'b0;
                            gap_cnt   <= '0;
                            eng_state <= E_GAP;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                            shreg   <= {shreg[14:0], 1'b0};
                            DIN     <= shreg[14];
                        end
                    end
                end
                E_GAP: begin
                    if (gap_last) begin
                        if (start) begin
                            eng_state <= E_LOAD;
                        end else begin
                            eng_state <= E_READY;
                            busy      <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: eng_state <= E_READY;
            endcase
        end
    end

`ifdef MAX7219_REINIT_EN
    logic [23:0] reinit_cnt;

    // Pending flag waits for IDLE so an active burst is never cut short
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reinit_cnt  <= 24'd0;
            reinit_pend <= 1'b0;
        end else if (top_state == T_IDLE && reinit_pend) begin
            reinit_cnt  <= 24'd0;
            reinit_pend <= 1'b0;
        end else if (reinit_cnt == REINIT_TICKS) begin
            reinit_pend <= 1'b1;
        end else begin
            reinit_cnt <= reinit_cnt + 24'd1;
        end
    end
`else
    logic unused_reinit_ticks;
    assign reinit_pend         = 1'b0;
    assign unused_reinit_ticks = ^REINIT_TICKS;
`endif

endmodule

// File: tb/tb_max7219_glyph_driver.sv
// Directed bench for max7219_glyph_driver: frames are captured from DIN/CS/SCLK and
// compared against hand-written glyph tables.
module tb_max7219_glyph_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit;
    logic       enable_display;
    logic       DIN, CS, SCLK, busy;

    logic [3:0] f_code;
    logic [2:0] f_row;
    logic [7:0] f_data;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [63:0] G_BLANK = 64'h0;
    localparam logic [63:0] G3      = 64'h3C66_061C_0666_3C00;
    localparam logic [63:0] G4      = 64'h0C1C_3C6C_7E0C_0C00;
    localparam logic [63:0] G5      = 64'h7E60_7C06_0666_3C00;
    localparam logic [63:0] G9      = 64'h3C66_663E_060C_3800;
    localparam logic [63:0] G_SAD   = 64'h3C42_A581_99A5_423C;

    logic [15:0] init_exp [5] = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A08, 16'h0F00};

    max7219_glyph_driver #(
        .CLK_DIV      (2),
        .CS_GAP       (4),
        .INTENSITY    (4'h8),
        .REINIT_TICKS (24'd5000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .digit          (digit),
        .enable_display (enable_display),
        .DIN            (DIN),
        .CS             (CS),
        .SCLK           (SCLK),
        .busy           (busy)
    );

    max7219_font u_font (
        .code (f_code),
        .row  (f_row),
        .data (f_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame monitor, sampled on the falling clock edge
    logic [15:0] fq[$];
    int          eq[$];
    int          lq[$];
    int          gq[$];
    logic [15:0] m_bits;
    int          m_edges, m_low, m_gap, m_din_err;
    logic        m_pcs, m_psclk, m_pdin;

    initial m_din_err = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_bits = 16'h0; m_edges = 0; m_low = 0; m_gap = 0;
            m_pcs = 1'b1; m_psclk = 1'b0; m_pdin = 1'b0;
        end else begin
            if (!CS && m_pcs) begin
                gq.push_back(m_gap);
                m_low = 0; m_edges = 0; m_bits = 16'h0;
            end
            if (!CS) begin
                m_low++;
                if (SCLK && !m_psclk) begin
                    m_bits = {m_bits[14:0], DIN};
                    m_edges++;
                end
                if (!m_pcs && DIN !== m_pdin && !(m_psclk && !SCLK))
                    m_din_err++;
            end
            if (CS && !m_pcs) begin
                fq.push_back(m_bits); eq.push_back(m_edges); lq.push_back(m_low);
                m_gap = 1;
            end else if (CS) begin
                m_gap++;
            end
            m_pcs = CS; m_psclk = SCLK; m_pdin = DIN;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] row_word(input logic [63:0] g, input int r);
        return {4'h0, r[3:0], g[(8 - r) * 8 +: 8]};
    endfunction

    task automatic wait_frames(input string tag, input int n, input int budget);
        int b = budget;
        while (fq.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        chk({tag, "_count"}, fq.size(), n);
    endtask

    task automatic wait_cs_low(input string tag, input int budget);
        int b = budget;
        while (CS !== 1'b0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        chk(tag, CS, 1'b0);
    endtask

    task automatic expect_frame(input string tag, input logic [15:0] w, input bit do_gap);
        int e, l, g;
        if (fq.size() == 0) begin
            chk({tag, "_present"}, 0, 1);
            return;
        end
        chk(tag, fq.pop_front(), w);
        e = eq.pop_front();
        l = lq.pop_front();
        g = gq.pop_front();
        chk({tag, "_sclk_edges"}, e, 16);
        chk({tag, "_cs_low"}, l, 64);
        if (do_gap)
            chk({tag, "_gap_ge4"}, g >= 4, 1);
    endtask

    task automatic expect_burst(input string tag, input logic [63:0] g);
        for (int r = 1; r <= 8; r++)
            expect_frame($sformatf("%s_row%0d", tag, r), row_word(g, r), 1'b1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        repeat (cycles) @(negedge clk);
        chk({tag, "_no_frames"}, fq.size(), 0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_cs"}, CS, 1'b1);
    endtask

    task automatic font_probe(input string tag, input logic [3:0] c, input logic [2:0] r,
                              input logic [7:0] exp);
        f_code = c;
        f_row  = r;
        #1;
        chk(tag, f_data, exp);
    endtask

    initial begin
        rst = 1'b1;
        digit = 4'd0;
        enable_display = 1'b0;
        f_code = 4'd0;
        f_row = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_cs", CS, 1'b1);
        chk("rst_sclk", SCLK, 1'b0);
        chk("rst_din", DIN, 1'b0);
        chk("rst_busy", busy, 1'b0);

        font_probe("font_sad_r4", 4'd12, 3'd4, 8'h99);
        font_probe("font_happy_r4", 4'd10, 3'd4, 8'hA5);
        font_probe("font_neutral_r4", 4'd11, 3'd4, 8'hBD);
        font_probe("font_d3_r3", 4'd3, 3'd3, 8'h1C);
        font_probe("font_blank14_r0", 4'd14, 3'd0, 8'h00);
        font_probe("font_blank13_r7", 4'd13, 3'd7, 8'h00);

        // Boot: init sequence then forced blank burst
        @(negedge clk);
        rst = 1'b0;
        wait_frames("boot", 13, 2000);
        for (int i = 0; i < 5; i++)
            expect_frame($sformatf("init%0d", i), init_exp[i], i != 0);
        expect_burst("blank", G_BLANK);
        quiet("boot_idle", 100);

        // Glyph 3 with latency check
        digit = 4'd3;
        enable_display = 1'b1;
        @(negedge clk);
        chk("lat_load_cs", CS, 1'b1);
        chk("lat_load_busy", busy, 1'b1);
        @(negedge clk);
        chk("lat_shift_cs", CS, 1'b0);
        chk("lat_shift_din", DIN, 1'b0);
        wait_frames("g3", 8, 1000);
        expect_burst("g3", G3);
        quiet("g3_idle", 100);

        // Sad smiley, then disable with the glyph held
        digit = 4'd12;
        wait_frames("sad", 8, 1000);
        expect_burst("sad", G_SAD);
        enable_display = 1'b0;
        wait_frames("off", 8, 1000);
        expect_burst("off", G_BLANK);
        quiet("off_idle", 100);

        // Input changes mid-burst: current burst keeps its snapshot
        digit = 4'd5;
        enable_display = 1'b1;
        wait_frames("g5_first2", 2, 400);
        wait_cs_low("g5_row3_start", 50);
        digit = 4'd4;
        wait_frames("g5g4", 16, 2000);
        expect_burst("g5", G5);
        expect_burst("g4", G4);

        // Async reset during bit 7 of a frame
        digit = 4'd9;
        wait_cs_low("rst_frame_start", 200);
        repeat (34) @(negedge clk);
        chk("pre_rst_sclk", SCLK, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cs", CS, 1'b1);
        chk("async_rst_sclk", SCLK, 1'b0);
        repeat (3) @(negedge clk);
        fq.delete(); eq.delete(); lq.delete(); gq.delete();
        rst = 1'b0;
        wait_frames("reboot", 13, 2000);
        for (int i = 0; i < 5; i++)
            expect_frame($sformatf("reinit_seq%0d", i), init_exp[i], i != 0);
        expect_burst("g9", G9);

`ifdef MAX7219_REINIT_EN
        wait_frames("periodic", 13, 7000);
        for (int i = 0; i < 5; i++)
            expect_frame($sformatf("periodic_init%0d", i), init_exp[i], 1'b1);
        expect_burst("periodic_g9", G9);
`else
        quiet("no_reinit", 3000);
`endif

        chk("din_stable_while_sclk", m_din_err, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
